// File: rtl/adder_check_pkg.sv
// Shared types for the adder result checker: report colours, FSM state
// encoding and a saturating tally helper.
package adder_check_pkg;

  // Report colour codes; ordinals are fixed so loggers can decode them.
  typedef enum logic [2:0] {
    WHITE  = 3'd0,
    BLUE   = 3'd1,  // reserved, never emitted
    YELLOW = 3'd2,
    RED    = 3'd3,
    GREEN  = 3'd4
  } colour_t;

  // Checker FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t WAIT_EXP = 2'd1;
  localparam state_t REPORT   = 2'd2;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Increment a tally, sticking at the maximum value.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adder_result_checker_if.sv
// Handshake bundle between the checker, the reference model, the DUT
// under observation and the report logger.
interface adder_result_checker_if
  import adder_check_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             exp_valid;
  logic [WIDTH:0]   exp_sum;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH:0]   act_sum;
  logic             act_ready;
  logic             rpt_valid;
  logic             rpt_ready;
  colour_t          rpt_colour;
  logic [WIDTH:0]   rpt_exp;
  logic [WIDTH:0]   rpt_act;

  // Environment side: offers sums, consumes reports.
  modport master (
    output exp_valid, exp_sum, act_valid, act_sum, rpt_ready,
    input  exp_ready, act_ready, rpt_valid, rpt_colour, rpt_exp, rpt_act
  );

  // Checker side.
  modport slave (
    input  exp_valid, exp_sum, act_valid, act_sum, rpt_ready,
    output exp_ready, act_ready, rpt_valid, rpt_colour, rpt_exp, rpt_act
  );
endinterface

// File: rtl/adder_sync_fifo.sv
// Small synchronous FIFO with show-ahead head data, so the checker can
// compare against the oldest expected sum in the same cycle it pops it.
module adder_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/adder_result_checker.sv
// Pairs DUT adder sums with queued reference sums, emits a coloured
// report per comparison and keeps saturating pass/fail/orphan tallies.
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_result_checker_if.slave  bus,
  output logic [15:0]            pass_count,
  output logic [15:0]            fail_count,
  output logic [15:0]            orphan_count
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WIDTH:0] fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  colour_t        colour_reg, colour_next;
  logic [WIDTH:0] rpt_exp_reg, rpt_exp_next;
  logic [WIDTH:0] rpt_act_reg, rpt_act_next;
  logic           accept;
  logic           rpt_fire;

  // exp_ready depends only on FIFO occupancy, never on act_valid.
  assign push = bus.exp_valid && !fifo_full;

  adder_sync_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.exp_sum),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state, acceptance and report-capture decisions.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    colour_next  = colour_reg;
    rpt_exp_next = rpt_exp_reg;
    rpt_act_next = rpt_act_reg;
    accept       = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.act_valid) begin
          if (!fifo_empty) begin
            accept       = 1'b1;
            pop          = 1'b1;
            colour_next  = (bus.act_sum == fifo_head) ? GREEN : RED;
            rpt_exp_next = fifo_head;
            rpt_act_next = bus.act_sum;
            state_next   = REPORT;
          end else begin
            timer_next = '0;
            state_next = WAIT_EXP;
          end
        end
      end
      WAIT_EXP: begin
        if (!bus.act_valid) begin
          state_next = IDLE;
        end else if (!fifo_empty) begin
          accept       = 1'b1;
          pop          = 1'b1;
          colour_next  = (bus.act_sum == fifo_head) ? GREEN : RED;
          rpt_exp_next = fifo_head;
          rpt_act_next = bus.act_sum;
          state_next   = REPORT;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          // No reference arrived in time: retire the actual as an orphan.
          accept       = 1'b1;
          colour_next  = YELLOW;
          rpt_exp_next = '0;
          rpt_act_next = bus.act_sum;
          state_next   = REPORT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      REPORT: begin
        if (bus.rpt_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rpt_fire       = (state_reg == REPORT) && bus.rpt_ready;
  assign bus.exp_ready  = !fifo_full;
  assign bus.act_ready  = accept;
  assign bus.rpt_valid  = (state_reg == REPORT);
  assign bus.rpt_colour = (state_reg == REPORT) ? colour_reg : WHITE;
  assign bus.rpt_exp    = rpt_exp_reg;
  assign bus.rpt_act    = rpt_act_reg;

  // FSM and report register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      colour_reg  <= WHITE;
      rpt_exp_reg <= '0;
      rpt_act_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      colour_reg  <= colour_next;
      rpt_exp_reg <= rpt_exp_next;
      rpt_act_reg <= rpt_act_next;
    end
  end

  // Tallies advance only when the logger takes a report.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_count   <= '0;
      fail_count   <= '0;
      orphan_count <= '0;
    end else if (rpt_fire) begin
      case (colour_reg)
        GREEN:   pass_count   <= sat_inc(pass_count);
        RED:     fail_count   <= sat_inc(fail_count);
        YELLOW:  orphan_count <= sat_inc(orphan_count);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker (WIDTH=8, DEPTH=4, TIMEOUT=16).
module tb_adder_result_checker;
  typedef enum logic [2:0] {
    C_WHITE = 3'd0, C_BLUE = 3'd1, C_YELLOW = 3'd2, C_RED = 3'd3, C_GREEN = 3'd4
  } tb_colour_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pass_count, fail_count, orphan_count;
  int          errors = 0;
  int          checks = 0;
  int          first_n;

  adder_result_checker_if #(.WIDTH(8)) bus();

  adder_result_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .orphan_count (orphan_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    bus.exp_valid = 1'b0; bus.exp_sum = '0;
    bus.act_valid = 1'b0; bus.act_sum = '0;
    bus.rpt_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_exp_ready", bus.exp_ready, 1);
    chk("rst_act_ready", bus.act_ready, 0);
    chk("rst_rpt_valid", bus.rpt_valid, 0);
    chk("rst_colour", bus.rpt_colour, C_WHITE);
    chk("rst_rpt_exp", bus.rpt_exp, 0);
    chk("rst_rpt_act", bus.rpt_act, 0);
    chk("rst_counts", {pass_count, fail_count | orphan_count}, 0);
    rst = 1'b0;

    // GREEN: 0FF vs 0FF
    bus.exp_valid = 1'b1; bus.exp_sum = 9'h0FF;
    tick();
    bus.exp_valid = 1'b0;
    bus.act_valid = 1'b1; bus.act_sum = 9'h0FF; bus.rpt_ready = 1'b1;
    settle();
    chk("green_act_ready", bus.act_ready, 1);
    tick();
    bus.act_valid = 1'b0;
    settle();
    chk("green_rpt_valid", bus.rpt_valid, 1);
    chk("green_colour", bus.rpt_colour, C_GREEN);
    chk("green_rpt_exp", bus.rpt_exp, 9'h0FF);
    chk("green_rpt_act", bus.rpt_act, 9'h0FF);
    chk("green_act_ready_in_report", bus.act_ready, 0);
    $display("txn: green report exp=%0h act=%0h", bus.rpt_exp, bus.rpt_act);
    tick();
    chk("green_pass_count", pass_count, 1);
    chk("green_after_valid", bus.rpt_valid, 0);
    chk("green_after_colour", bus.rpt_colour, C_WHITE);

    // RED: carry bit mismatch 100 vs 000
    bus.exp_valid = 1'b1; bus.exp_sum = 9'h100;
    tick();
    bus.exp_valid = 1'b0;
    bus.act_valid = 1'b1; bus.act_sum = 9'h000;
    tick();
    bus.act_valid = 1'b0;
    settle();
    chk("red_colour", bus.rpt_colour, C_RED);
    chk("red_rpt_exp", bus.rpt_exp, 9'h100);
    chk("red_rpt_act", bus.rpt_act, 9'h000);
    $display("txn: red report exp=%0h act=%0h", bus.rpt_exp, bus.rpt_act);
    tick();
    chk("red_fail_count", fail_count, 1);
    chk("red_pass_count", pass_count, 1);

    // YELLOW: actual with no expected until timeout
    bus.act_valid = 1'b1; bus.act_sum = 9'h005;
    first_n = -1;
    for (int n = 0; n <= 40; n++) begin
      settle();
      if (bus.act_ready) begin first_n = n; break; end
      tick();
    end
    chk("timeout_cycle", first_n, 16);
    tick();
    bus.act_valid = 1'b0;
    settle();
    chk("yellow_colour", bus.rpt_colour, C_YELLOW);
    chk("yellow_rpt_exp", bus.rpt_exp, 0);
    chk("yellow_rpt_act", bus.rpt_act, 9'h005);
    $display("txn: yellow report act=%0h", bus.rpt_act);
    tick();
    chk("yellow_orphan_count", orphan_count, 1);

    // Expected arrives 5 cycles into the wait
    bus.act_valid = 1'b1; bus.act_sum = 9'h007;
    first_n = -1;
    for (int n = 0; n <= 40; n++) begin
      if (n == 5) begin bus.exp_valid = 1'b1; bus.exp_sum = 9'h007; end
      settle();
      if (bus.act_ready) begin first_n = n; break; end
      tick();
      bus.exp_valid = 1'b0;
    end
    chk("late_exp_accept_cycle", first_n, 6);
    tick();
    bus.act_valid = 1'b0;
    settle();
    chk("late_exp_colour", bus.rpt_colour, C_GREEN);
    $display("txn: late-exp report exp=%0h act=%0h", bus.rpt_exp, bus.rpt_act);
    tick();
    chk("late_exp_pass_count", pass_count, 2);
    chk("late_exp_orphan_count", orphan_count, 1);

    // FIFO full: five pushes, fifth held until a pop
    bus.rpt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.exp_valid = 1'b1; bus.exp_sum = 9'(9'h010 + k);
      settle();
      chk("fill_exp_ready", bus.exp_ready, 1);
      tick();
    end
    bus.exp_sum = 9'h014;
    settle();
    chk("full_exp_ready", bus.exp_ready, 0);
    bus.act_valid = 1'b1; bus.act_sum = 9'h010;
    settle();
    chk("full_pop_act_ready", bus.act_ready, 1);
    chk("full_exp_ready_indep", bus.exp_ready, 0);
    tick();
    bus.act_valid = 1'b0; bus.act_sum = 9'h011;
    settle();
    chk("after_pop_exp_ready", bus.exp_ready, 1);
    tick();
    bus.exp_valid = 1'b0;
    settle();
    chk("refull_exp_ready", bus.exp_ready, 0);

    // Stalled GREEN report: hold rpt_ready low for 10 cycles
    bus.act_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("stall_rpt_valid", bus.rpt_valid, 1);
      chk("stall_colour", bus.rpt_colour, C_GREEN);
      chk("stall_rpt_act", bus.rpt_act, 9'h010);
      chk("stall_act_ready", bus.act_ready, 0);
      chk("stall_pass_count", pass_count, 2);
      tick();
    end
    bus.rpt_ready = 1'b1;
    tick();
    chk("stall_release_pass", pass_count, 3);
    chk("stall_next_accept", bus.act_ready, 1);
    tick();
    settle();
    chk("queued_colour", bus.rpt_colour, C_GREEN);
    chk("queued_rpt_exp", bus.rpt_exp, 9'h011);
    tick();
    chk("queued_pass_count", pass_count, 4);

    // RED report pending with two entries queued, then reset
    bus.act_sum = 9'h0AA;
    tick();
    bus.act_valid = 1'b0;
    settle();
    chk("pre_rst_colour", bus.rpt_colour, C_RED);
    chk("pre_rst_rpt_exp", bus.rpt_exp, 9'h012);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_rst_rpt_valid", bus.rpt_valid, 0);
    chk("mid_rst_colour", bus.rpt_colour, C_WHITE);
    chk("mid_rst_rpt_exp", bus.rpt_exp, 0);
    chk("mid_rst_rpt_act", bus.rpt_act, 0);
    chk("mid_rst_exp_ready", bus.exp_ready, 1);
    chk("mid_rst_pass", pass_count, 0);
    chk("mid_rst_fail", fail_count, 0);
    chk("mid_rst_orphan", orphan_count, 0);
    bus.act_valid = 1'b1; bus.act_sum = 9'h012;
    settle();
    chk("mid_rst_fifo_empty", bus.act_ready, 0);
    bus.act_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, adder operand width; sums are WIDTH+1 bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, expected-result FIFO depth (power of 2, >=2).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, cycles an actual result may wait for a matching expected result.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 exp_valid  in  1  expected sum offered; exp_sum  in  WIDTH+1  reference-model sum; exp_ready  out  1  FIFO not full.
REQ-008 act_valid  in  1  DUT sum offered; act_sum  in  WIDTH+1  DUT sum; act_ready  out  1  actual accepted this cycle.
REQ-009 rpt_valid  out  1  report held; rpt_ready  in  1  logger consumes report; rpt_colour  out  3  colour_t code; rpt_exp, rpt_act  out  WIDTH+1  compared values.
REQ-010 pass_count, fail_count, orphan_count  out  16 each  saturating tallies.

Function
REQ-011 Expected transfer SHALL occur on exp_valid && exp_ready; exp_ready SHALL be low only when the FIFO holds DEPTH entries.
REQ-012 Simultaneous push and pop on a full FIFO SHALL be allowed only if a pop occurs that cycle; exp_ready SHALL NOT depend combinationally on act_valid.
REQ-013 FSM states SHALL be IDLE, WAIT_EXP, REPORT.
REQ-014 IDLE: act_valid && FIFO non-empty -> act_ready=1, pop head, register report, go REPORT (report visible 1 cycle after acceptance).
REQ-015 IDLE: act_valid && FIFO empty -> act_ready=0, clear timer, go WAIT_EXP.
REQ-016 WAIT_EXP: FIFO becomes non-empty -> accept and compare as in REQ-014; else timer increments; timer reaching TIMEOUT-1 -> act_ready=1, report colour YELLOW with rpt_exp=0, go REPORT.
REQ-017 WAIT_EXP: act_valid dropping SHALL return FSM to IDLE with no report.
REQ-018 Compare: rpt_colour=GREEN if act_sum==exp_sum, else RED; full WIDTH+1 bits compared including carry-out.
REQ-019 REPORT: rpt_valid=1, outputs stable until rpt_ready; on rpt_valid && rpt_ready go IDLE; act_ready=0 throughout REPORT (max one comparison per two cycles).
REQ-020 Counters SHALL increment on report acceptance (rpt_valid && rpt_ready): GREEN->pass, RED->fail, YELLOW->orphan; each saturates at 16'hFFFF.
REQ-021 A late expected result after a YELLOW orphan SHALL remain in the FIFO and pair with the next actual (no resynchronisation).
REQ-022 rpt_colour SHALL be WHITE whenever rpt_valid=0.

Reset
REQ-023 On rst: FSM=IDLE, FIFO empty, timer=0, exp_ready=1, act_ready=0, rpt_valid=0, rpt_colour=WHITE, rpt_exp=rpt_act=0, all counters 0.
REQ-024 rst mid-REPORT SHALL drop the pending report uncounted; rst SHALL take priority over every transfer in the same cycle.

Structure
REQ-025 Shared package adder_check_pkg SHALL hold colour_t (3-bit: WHITE=0, BLUE=1, YELLOW=2, RED=3, GREEN=4, ordinals matching the testbench colour enum) and the FSM state typedef.
REQ-026 The FIFO SHALL be sub-module adder_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty; same clk/rst).
REQ-027 BLUE is reserved; the block SHALL never emit it.

Verification
REQ-028 Push exp 9'h0FF, then act 9'h0FF, rpt_ready=1 -> one GREEN report next cycle after acceptance, pass_count=1.
REQ-029 Push exp 9'h100, act 9'h000 -> RED report, rpt_exp=9'h100, rpt_act=9'h000, fail_count=1 (carry-bit mismatch detected).
REQ-030 act 9'h005 with empty FIFO held 16 cycles -> YELLOW report on timeout, orphan_count=1; exp pushed at cycle 5 instead -> GREEN/RED compare, no orphan.
REQ-031 Push 5 expected with DEPTH=4, no actuals -> exp_ready low after 4th push, 5th held until first pop.
REQ-032 GREEN report with rpt_ready=0 for 10 cycles -> rpt_* stable, act_ready=0, pass_count unchanged until acceptance.
REQ-033 Assert rst during REPORT with 2 FIFO entries -> all outputs at REQ-023 values next cycle, counters 0.
